// File: rtl/instr_prefetch_queue.sv
// Purpose : instruction prefetch queue between the PC fetch stage and decode.
// Latency : a PC issued in cycle N is visible on dec_* in cycle N+2 (1-cycle imem plus the capture register).
// Backpr. : fetch_stall is raised while queued + in-flight entries reach DEPTH; decode drains with valid/ready.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   fetch_pc/valid      PC from the fetch stage and its request qualifier
//   redirect            branch/jump taken: flush queue and in-flight fetch
//   imem_addr/data      synchronous instruction memory (address out, word back one cycle later)
//   fetch_stall         fetch stage holds its PC this cycle
//   dec_valid/ready     head-of-queue handshake to decode
//   dec_instr/pc        head entry, forced to 0 when the queue is empty
//   count               occupied entries
module instr_prefetch_queue #(
  parameter int INSTR_W = 9,
  parameter int PC_W    = 10,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    fetch_pc,
  input  logic               fetch_valid,
  input  logic               redirect,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               fetch_stall,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               inflight;
  logic [PC_W-1:0]    inflight_pc;
  logic [CNT_W:0]     occupancy;
  logic               issue;
  logic               push;
  logic               pop;

  // Storage is deliberately left without reset: empty outputs are masked below.
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];

  assign imem_addr = fetch_pc;

  // Slots are reserved at issue time by counting the in-flight fetch, so a
  // capture can never find the queue full. A same-cycle pop is not credited,
  // which keeps the stall path free of dec_ready.
  assign occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign fetch_stall = (occupancy >= DEPTH_W);

  assign issue     = fetch_valid & ~fetch_stall & ~redirect;
  assign push      = inflight & ~redirect;
  assign dec_valid = (count != '0);
  assign pop       = dec_valid & dec_ready & ~redirect;

  assign dec_instr = dec_valid ? instr_mem[rd_ptr] : '0;
  assign dec_pc    = dec_valid ? pc_mem[rd_ptr]    : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      // Flush: the word returning this cycle belongs to the wrong path.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_data;
      pc_mem[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;

  localparam int INSTR_W = 9;
  localparam int PC_W    = 10;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 3;

  logic               clk;
  logic               reset;
  logic [PC_W-1:0]    fetch_pc;
  logic               fetch_valid;
  logic               redirect;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               fetch_stall;
  logic               dec_valid;
  logic               dec_ready;
  logic [INSTR_W-1:0] dec_instr;
  logic [PC_W-1:0]    dec_pc;
  logic [CNT_W-1:0]   count;

  logic [PC_W-1:0]    redirect_target;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t exp_q[$];
  int     checks;
  int     errors;

  instr_prefetch_queue #(
    .INSTR_W(INSTR_W), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_pc   (fetch_pc),
    .fetch_valid(fetch_valid),
    .redirect   (redirect),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .fetch_stall(fetch_stall),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_instr  (dec_instr),
    .dec_pc     (dec_pc),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a function of address.
  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] pc);
    return pc[INSTR_W-1:0] ^ 9'h0A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [PC_W-1:0] pc);
    entry_t e;
    e.pc    = pc;
    e.instr = instr_of(pc);
    exp_q.push_back(e);
  endtask

  // One cycle of the fetch stage + memory: entered at edge+1, returns at next edge+1.
  task automatic tick();
    logic            iss;
    logic            redir;
    logic [PC_W-1:0] addr;
    #2;
    iss   = fetch_valid && !fetch_stall && !redirect;
    redir = redirect;
    addr  = imem_addr;
    @(posedge clk);
    #1;
    imem_data = instr_of(addr);
    if (redir)    fetch_pc = redirect_target;
    else if (iss) fetch_pc = fetch_pc + 1'b1;
  endtask

  // Scoreboard monitor: compares every accepted head entry against the expected stream.
  always @(negedge clk) begin
    if (!reset && dec_valid && dec_ready && !redirect) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got pc 0x%0h, expected no entry", dec_pc);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        if (dec_pc !== e.pc || dec_instr !== e.instr) begin
          errors++;
          $display("FAIL pop_entry: got pc 0x%0h instr 0x%0h expected pc 0x%0h instr 0x%0h",
                   dec_pc, dec_instr, e.pc, e.instr);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    fetch_pc = '0;
    fetch_valid = 1'b0;
    redirect = 1'b0;
    redirect_target = '0;
    dec_ready = 1'b0;
    imem_data = '0;

    // Reset state, before any clock edge.
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_dec_valid", 32'(dec_valid), 0);
    chk("rst_stall", 32'(fetch_stall), 0);
    chk("rst_dec_pc", 32'(dec_pc), 0);
    chk("rst_dec_instr", 32'(dec_instr), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: pc 0,1,2 with decode always ready.
    push_exp(10'h000); push_exp(10'h001); push_exp(10'h002);
    fetch_pc = 10'h000; fetch_valid = 1'b1; dec_ready = 1'b1;
    tick();
    chk("t1_lat_not_yet", 32'(dec_valid), 0);
    tick();
    chk("t1_lat_valid", 32'(dec_valid), 1);
    chk("t1_lat_pc", 32'(dec_pc), 32'h000);
    chk("t1_lat_instr", 32'(dec_instr), 32'(instr_of(10'h000)));
    tick();
    fetch_valid = 1'b0;
    repeat (4) tick();
    chk("t1_count_empty", 32'(count), 0);
    chk("t1_sb_empty", 32'(exp_q.size()), 0);

    // 2: fill with decode stalled.
    for (int i = 0; i < 10; i++) push_exp(10'(i));
    fetch_pc = 10'h000; fetch_valid = 1'b1; dec_ready = 1'b0;
    tick(); tick(); tick();
    chk("t2_stall_low_occ3", 32'(fetch_stall), 0);
    tick();
    chk("t2_stall_high_occ4", 32'(fetch_stall), 1);
    chk("t2_count3", 32'(count), 3);
    tick(); tick();
    chk("t2_count_full", 32'(count), 4);
    chk("t2_stall_full", 32'(fetch_stall), 1);
    chk("t2_head_pc", 32'(dec_pc), 32'h000);

    // 3: drain for 10 cycles while fetch refills, crossing the pointer wrap.
    dec_ready = 1'b1;
    repeat (10) tick();
    dec_ready = 1'b0;
    chk("t3_all_popped", 32'(exp_q.size()), 0);

    // 4: three queued plus one in flight, then redirect to 0x200.
    tick();
    chk("t4_pre_count", 32'(count), 3);
    chk("t4_pre_stall", 32'(fetch_stall), 1);
    redirect = 1'b1; redirect_target = 10'h200;
    exp_q.delete();
    push_exp(10'h200); push_exp(10'h201);
    tick();
    redirect = 1'b0;
    chk("t4_flush_count", 32'(count), 0);
    chk("t4_flush_valid", 32'(dec_valid), 0);
    chk("t4_flush_pc", 32'(dec_pc), 0);
    tick();
    chk("t4_stale_dropped", 32'(count), 0);
    tick();
    fetch_valid = 1'b0;
    chk("t4_target_count", 32'(count), 1);
    chk("t4_target_pc", 32'(dec_pc), 32'h200);
    chk("t4_target_instr", 32'(dec_instr), 32'(instr_of(10'h200)));
    tick();
    chk("t5_two_queued", 32'(count), 2);

    // 5: halted fetch, queue drains.
    dec_ready = 1'b1;
    repeat (5) tick();
    chk("t5_count_empty", 32'(count), 0);
    chk("t5_valid_low", 32'(dec_valid), 0);
    chk("t5_sb_empty", 32'(exp_q.size()), 0);

    // 6: asynchronous reset between edges while full.
    dec_ready = 1'b0; fetch_valid = 1'b1; fetch_pc = 10'h040;
    repeat (4) tick();
    chk("t6_pre_stall", 32'(fetch_stall), 1);
    chk("t6_pre_count", 32'(count), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_count", 32'(count), 0);
    chk("t6_async_valid", 32'(dec_valid), 0);
    chk("t6_async_stall", 32'(fetch_stall), 0);
    chk("t6_async_pc", 32'(dec_pc), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    fetch_pc = 10'h080; fetch_valid = 1'b1; dec_ready = 1'b1;
    push_exp(10'h080); push_exp(10'h081);
    tick(); tick();
    fetch_valid = 1'b0;
    chk("t6_restart_valid", 32'(dec_valid), 1);
    chk("t6_restart_pc", 32'(dec_pc), 32'h080);
    repeat (4) tick();
    chk("t6_count_empty", 32'(count), 0);
    chk("t6_sb_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
